// File: rtl/alarme_pkg.sv
// Shared types and constants for the alarm controller.
// Build option: SONECA_EN enables the snooze state and its counters.
package alarme_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_H   = 3'd1,
    SET_M   = 3'd2,
    RINGING = 3'd3,
    SNOOZE  = 3'd4
  } state_t;

  localparam logic [5:0] MAX_HORA = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  localparam logic [1:0] MODO_NORMAL = 2'd0;
  localparam logic [1:0] MODO_SET_H  = 2'd1;
  localparam logic [1:0] MODO_SET_M  = 2'd2;
  localparam logic [1:0] MODO_ALARME = 2'd3;

  // Ringing and snooze share the same user-visible mode code.
  function automatic logic [1:0] modo_of(input state_t s);
    logic [1:0] m;
    m = MODO_NORMAL;
    case (s)
      SET_H:   m = MODO_SET_H;
      SET_M:   m = MODO_SET_M;
      RINGING: m = MODO_ALARME;
      SNOOZE:  m = MODO_ALARME;
      default: m = MODO_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alarme_controller_contador_wrap.sv
// Six-bit up/down counter that wraps between MAX and 0; holds one alarm field.
module contador_wrap #(
  parameter logic [5:0] MAX = 6'd59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [5:0] val_o
);

  logic [5:0] val_q, val_d;

  // Next value: increment wins over decrement; wrap at both ends.
  always_comb begin
    val_d = val_q;
    if (inc_i) begin
      val_d = (val_q >= MAX) ? 6'd0 : val_q + 6'd1;
    end else if (dec_i) begin
      val_d = (val_q == 6'd0) ? MAX : val_q - 6'd1;
    end
  end

  // Field register, cleared by reset (the alarm time does not survive reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= 6'd0;
    else     val_q <= val_d;
  end

  assign val_o = val_q;

endmodule

// File: rtl/alarme_controller.sv
// Alarm controller: holds the alarm time, detects the HH:MM:00 match on the
// running clock and sequences ringing, snooze and auto-off. Read-only on time.
// Build option: SONECA_EN enables snooze; without it btn_snooze has no effect.
module alarme_controller
  import alarme_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_enable,
  input  logic       btn_snooze,
  input  logic [5:0] segundos,
  input  logic [5:0] minutos,
  input  logic [5:0] horas,
  output logic [5:0] alarme_horas,
  output logic [5:0] alarme_minutos,
  output logic       alarme_ativo,
  output logic       tocando,
  output logic       soneca_ativa,
  output logic [1:0] modo_alarme
);

  if (RING_SECONDS < 1 || RING_SECONDS > 255 ||
      SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 15 ||
      MAX_SNOOZES < 1 || MAX_SNOOZES > 7) begin : g_bad_params
    $error("alarme_controller: parameter out of range");
  end

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  state_t     state_q, state_d;
  logic [5:0] seg_q;
  logic       ativo_q, ativo_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       tocando_q, soneca_q;
  logic [1:0] modo_q;
  logic       sec_tick, trigger;
  logic       act_mode, act_enable, act_snooze, act_inc, act_dec;

`ifdef SONECA_EN
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MINUTES * 60);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZES);
  logic [9:0] snooze_cnt_q, snooze_cnt_d;
  logic [2:0] snoozes_used_q, snoozes_used_d;
`endif

  // Any change of the seconds value (normal count or adjustment jump) is a tick.
  assign sec_tick = (segundos != seg_q);

  // Only the highest-priority pulse in a cycle is allowed to act.
  assign act_mode   = btn_mode;
  assign act_enable = btn_enable & ~btn_mode;
  assign act_snooze = btn_snooze & ~btn_mode & ~btn_enable;
  assign act_inc    = btn_inc & ~btn_mode & ~btn_enable & ~btn_snooze;
  assign act_dec    = btn_dec & ~btn_mode & ~btn_enable & ~btn_snooze & ~btn_inc;

  // Edge-based match: fires once on the tick that lands on HH:MM:00.
  assign trigger = ativo_q && sec_tick && (segundos == 6'd0) &&
                   (horas == alarme_horas) && (minutos == alarme_minutos);

  contador_wrap #(.MAX(MAX_HORA)) u_horas (
    .clk   (clk_100MHz),
    .rst   (rst),
    .inc_i (act_inc && (state_q == SET_H)),
    .dec_i (act_dec && (state_q == SET_H)),
    .val_o (alarme_horas)
  );

  contador_wrap #(.MAX(MAX_MIN)) u_minutos (
    .clk   (clk_100MHz),
    .rst   (rst),
    .inc_i (act_inc && (state_q == SET_M)),
    .dec_i (act_dec && (state_q == SET_M)),
    .val_o (alarme_minutos)
  );

  // Next-state logic: button actions take precedence over second ticks.
  always_comb begin
    state_d    = state_q;
    ativo_d    = ativo_q;
    ring_cnt_d = ring_cnt_q;
`ifdef SONECA_EN
    snooze_cnt_d   = snooze_cnt_q;
    snoozes_used_d = snoozes_used_q;
`endif
    case (state_q)
      IDLE: begin
        if (act_mode) begin
          state_d = SET_H;
        end else if (act_enable) begin
          ativo_d = ~ativo_q;
        end else if (trigger) begin
          state_d    = RINGING;
          ring_cnt_d = 8'd0;
`ifdef SONECA_EN
          snoozes_used_d = 3'd0;
`endif
        end
      end
      SET_H: if (act_mode) state_d = SET_M;
      SET_M: if (act_mode) state_d = IDLE;
      RINGING: begin
        if (act_mode) begin
          state_d = IDLE;
        end else if (act_enable) begin
          state_d = IDLE;
          ativo_d = 1'b0;
        end
`ifdef SONECA_EN
        else if (act_snooze && (snoozes_used_q < SNOOZE_MAX)) begin
          state_d        = SNOOZE;
          snooze_cnt_d   = SNOOZE_LOAD;
          snoozes_used_d = snoozes_used_q + 3'd1;
        end
`endif
        else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) state_d = IDLE;
          else                         ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
`ifdef SONECA_EN
      SNOOZE: begin
        if (act_mode) begin
          state_d = IDLE;
        end else if (act_enable) begin
          state_d = IDLE;
          ativo_d = 1'b0;
        end else if (sec_tick) begin
          if (snooze_cnt_q == 10'd1) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end else begin
            snooze_cnt_d = snooze_cnt_q - 10'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      seg_q      <= 6'd0;
      ativo_q    <= 1'b0;
      ring_cnt_q <= 8'd0;
      tocando_q  <= 1'b0;
      soneca_q   <= 1'b0;
      modo_q     <= MODO_NORMAL;
`ifdef SONECA_EN
      snooze_cnt_q   <= 10'd0;
      snoozes_used_q <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      seg_q      <= segundos;
      ativo_q    <= ativo_d;
      ring_cnt_q <= ring_cnt_d;
      tocando_q  <= (state_d == RINGING);
      modo_q     <= modo_of(state_d);
`ifdef SONECA_EN
      soneca_q       <= (state_d == SNOOZE);
      snooze_cnt_q   <= snooze_cnt_d;
      snoozes_used_q <= snoozes_used_d;
`else
      soneca_q       <= 1'b0;
`endif
    end
  end

  assign alarme_ativo = ativo_q;
  assign tocando      = tocando_q;
  assign soneca_ativa = soneca_q;
  assign modo_alarme  = modo_q;

endmodule

// File: tb/tb_alarme_controller.sv
// Directed bench for alarme_controller with a scoreboard of expected values.
// Build option: SONECA_EN selects the snooze scenario; otherwise snooze is
// checked to have no effect.
module tb_alarme_controller;

  logic       clk_100MHz = 1'b0;
  logic       rst;
  logic [4:0] btns;
  logic [5:0] segundos, minutos, horas;
  logic [5:0] alarme_horas, alarme_minutos;
  logic       alarme_ativo, tocando, soneca_ativa;
  logic [1:0] modo_alarme;

  localparam logic [4:0] B_MODE = 5'b00001;
  localparam logic [4:0] B_INC  = 5'b00010;
  localparam logic [4:0] B_DEC  = 5'b00100;
  localparam logic [4:0] B_EN   = 5'b01000;
  localparam logic [4:0] B_SNZ  = 5'b10000;

  typedef struct {
    string      tag;
    logic [9:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_run  = 0;
  int  n_fail = 0;
  int  th = 0, tm = 0, ts = 0;
  logic ring_seen;

  always #5 clk_100MHz = ~clk_100MHz;

  alarme_controller dut (
    .clk_100MHz     (clk_100MHz),
    .rst            (rst),
    .btn_mode       (btns[0]),
    .btn_inc        (btns[1]),
    .btn_dec        (btns[2]),
    .btn_enable     (btns[3]),
    .btn_snooze     (btns[4]),
    .segundos       (segundos),
    .minutos        (minutos),
    .horas          (horas),
    .alarme_horas   (alarme_horas),
    .alarme_minutos (alarme_minutos),
    .alarme_ativo   (alarme_ativo),
    .tocando        (tocando),
    .soneca_ativa   (soneca_ativa),
    .modo_alarme    (modo_alarme)
  );

  task automatic push(input string tag, input logic [9:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [9:0] obs);
    sb_t e;
    n_run++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0d required an entry", obs);
    end else begin
      e = sb_q.pop_front();
      $display("[TB] %s observed=%0d expected=%0d", e.tag, obs, e.val);
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic press(input logic [4:0] b);
    btns = b;
    @(posedge clk_100MHz); #1;
    btns = 5'b0;
  endtask

  task automatic drive_time();
    horas = 6'(th); minutos = 6'(tm); segundos = 6'(ts);
    @(posedge clk_100MHz); #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
    drive_time();
  endtask

  task automatic sec_step();
    ts++;
    if (ts == 60) begin ts = 0; tm++; end
    if (tm == 60) begin tm = 0; th++; end
    if (th == 24) th = 0;
    drive_time();
  endtask

  task automatic check_all_zero(input string pfx);
    push({pfx, "_horas"}, 0);   push({pfx, "_minutos"}, 0);
    push({pfx, "_ativo"}, 0);   push({pfx, "_tocando"}, 0);
    push({pfx, "_soneca"}, 0);  push({pfx, "_modo"}, 0);
    check(alarme_horas); check(alarme_minutos); check(alarme_ativo);
    check(tocando); check(soneca_ativa); check(modo_alarme);
  endtask

  // Alarm is 07:30 armed: walk the clock onto 07:30:00 and expect ringing.
  task automatic ring_up(input string tag);
    set_time(7, 29, 59);
    push(tag, 1);
    sec_step();
    check(tocando);
  endtask

  initial begin
    rst = 1'b1; btns = 5'b0;
    horas = 6'd0; minutos = 6'd0; segundos = 6'd0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk_100MHz); #1;

    // Coincident mode+inc in IDLE: only mode acts.
    push("prio_modo", 1); push("prio_horas", 0);
    press(B_MODE | B_INC);
    check(modo_alarme); check(alarme_horas);
    push("hour_dec_wrap", 23); press(B_DEC); check(alarme_horas);
    push("hour_inc_wrap", 0);  press(B_INC); check(alarme_horas);
    push("set_h_enable_ignored", 0); press(B_EN); check(alarme_ativo);
    repeat (7) press(B_INC);
    push("hour_set", 7); check(alarme_horas);
    push("modo_set_m", 2); press(B_MODE); check(modo_alarme);
    push("min_dec_wrap", 59); press(B_DEC); check(alarme_minutos);
    push("min_inc_wrap", 0);  press(B_INC); check(alarme_minutos);
    repeat (30) press(B_INC);
    push("min_set", 30); check(alarme_minutos);
    push("modo_normal", 0); press(B_MODE); check(modo_alarme);
    push("hour_kept", 7); check(alarme_horas);
    push("armed", 1); press(B_EN); check(alarme_ativo);

    // Trigger and auto-off after RING_SECONDS ticks.
    set_time(7, 29, 59);
    push("pre_trigger", 0); check(tocando);
    push("trigger_tocando", 1); push("trigger_modo", 3);
    sec_step();
    check(tocando); check(modo_alarme);
    repeat (59) sec_step();
    push("ring_tick59", 1); check(tocando);
    push("autooff_tocando", 0); push("autooff_modo", 0); push("autooff_ativo", 1);
    sec_step();
    check(tocando); check(modo_alarme); check(alarme_ativo);

    // Stop with enable disarms; stop with mode keeps armed, no retrigger.
    ring_up("ring_for_enable");
    push("en_stop_tocando", 0); push("en_stop_ativo", 0); push("en_stop_modo", 0);
    press(B_EN);
    check(tocando); check(alarme_ativo); check(modo_alarme);
    push("rearm", 1); press(B_EN); check(alarme_ativo);
    ring_up("ring_for_mode");
    push("mode_stop_tocando", 0); push("mode_stop_ativo", 1); push("mode_stop_modo", 0);
    press(B_MODE);
    check(tocando); check(alarme_ativo); check(modo_alarme);
    ring_seen = 1'b0;
    repeat (59) begin
      sec_step();
      if (tocando) ring_seen = 1'b1;
    end
    push("no_retrigger", 0); check(ring_seen);

`ifdef SONECA_EN
    ring_up("ring_for_snooze");
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("snz%0d_soneca", k), 1);
      push($sformatf("snz%0d_tocando", k), 0);
      push($sformatf("snz%0d_modo", k), 3);
      press(B_SNZ);
      check(soneca_ativa); check(tocando); check(modo_alarme);
      repeat (299) sec_step();
      push($sformatf("snz%0d_tick299", k), 1); check(soneca_ativa);
      push($sformatf("snz%0d_reling_tocando", k), 1);
      push($sformatf("snz%0d_reling_soneca", k), 0);
      sec_step();
      check(tocando); check(soneca_ativa);
    end
    push("snz4_tocando", 1); push("snz4_soneca", 0);
    press(B_SNZ);
    check(tocando); check(soneca_ativa);
    push("snz_mode_exit", 0); press(B_MODE); check(modo_alarme);

    ring_up("ring_for_rst");
    push("snz_before_rst", 1); press(B_SNZ); check(soneca_ativa);
    @(negedge clk_100MHz);
    rst = 1'b1;
    #1;
    check_all_zero("rst_in_snooze");
`else
    ring_up("ring_no_soneca");
    push("nosnz_tocando", 1); push("nosnz_soneca", 0); push("nosnz_modo", 3);
    press(B_SNZ);
    check(tocando); check(soneca_ativa); check(modo_alarme);
    repeat (5) sec_step();
    push("nosnz_later_tocando", 1); push("nosnz_later_soneca", 0);
    check(tocando); check(soneca_ativa);
    @(negedge clk_100MHz);
    rst = 1'b1;
    #1;
    check_all_zero("rst_in_ringing");
`endif
    @(posedge clk_100MHz); #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
